// File: rtl/imm_extend_pipe.sv
// Immediate extender (sign/zero/upper/sign<<2), optional IMM_EXT_STATS_EN output-handshake counter.
// Latency 1 cycle; full throughput via output reg plus one skid reg.
// Backpressure: in_ready_o drops (registered) once the skid reg holds an entry; flush_i empties both.
module imm_extend_pipe #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int STAT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       mode_i,
    input  logic [IN_W-1:0]  data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] data_o,
    output logic             neg_o
`ifdef IMM_EXT_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_cnt_o
`endif
);

    localparam int EXT_W = OUT_W - IN_W;

    function automatic logic [OUT_W-1:0] extend(input logic [1:0] m, input logic [IN_W-1:0] d);
        logic [OUT_W-1:0] sx;
        logic [OUT_W-1:0] zx;
        sx = {{EXT_W{d[IN_W-1]}}, d};
        zx = {{EXT_W{1'b0}}, d};
        case (m)
            2'b00:   return sx;
            2'b01:   return zx;
            2'b10:   return zx << IN_W;
            default: return sx << 2;
        endcase
    endfunction

    logic             or_vld_q, or_vld_d;
    logic             sk_vld_q, sk_vld_d;
    logic [OUT_W-1:0] or_dat_q, or_dat_d;
    logic [OUT_W-1:0] sk_dat_q, sk_dat_d;
    logic             in_fire;
    logic             out_fire;
    logic [OUT_W-1:0] ext_dat;

    // Ready depends only on the skid flop; rst_i gates it so nothing is accepted during reset.
    assign in_ready_o  = ~sk_vld_q & ~rst_i;
    assign out_valid_o = or_vld_q;
    assign data_o      = or_dat_q;
    assign neg_o       = or_vld_q & or_dat_q[OUT_W-1];

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = or_vld_q & out_ready_i;
    assign ext_dat  = extend(mode_i, data_i);

    always_comb begin
        or_vld_d = or_vld_q;
        sk_vld_d = sk_vld_q;
        or_dat_d = or_dat_q;
        sk_dat_d = sk_dat_q;
        if (flush_i) begin
            or_vld_d = 1'b0;
            sk_vld_d = 1'b0;
        end else if (!or_vld_q || out_fire) begin
            if (sk_vld_q) begin
                or_vld_d = 1'b1;
                or_dat_d = sk_dat_q;
                sk_vld_d = 1'b0;
            end else begin
                or_vld_d = in_fire;
                if (in_fire) begin
                    or_dat_d = ext_dat;
                end
            end
        end else if (in_fire) begin
            sk_vld_d = 1'b1;
            sk_dat_d = ext_dat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            or_vld_q <= 1'b0;
            sk_vld_q <= 1'b0;
            or_dat_q <= '0;
            sk_dat_q <= '0;
        end else begin
            or_vld_q <= or_vld_d;
            sk_vld_q <= sk_vld_d;
            or_dat_q <= or_dat_d;
            sk_dat_q <= sk_dat_d;
        end
    end

`ifdef IMM_EXT_STATS_EN
    logic [STAT_W-1:0] stat_cnt_q, stat_cnt_d;

    // Saturating; flush does not clear it since flushed-cycle deliveries still count.
    always_comb begin
        stat_cnt_d = stat_cnt_q;
        if (out_fire && (stat_cnt_q != {STAT_W{1'b1}})) begin
            stat_cnt_d = stat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_cnt_q <= '0;
        end else begin
            stat_cnt_q <= stat_cnt_d;
        end
    end

    assign stat_cnt_o = stat_cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: spec-constant vector table, directed stall/flush/reset sequences, random traffic vs a queue model.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, in_valid_i, out_ready_i;
    logic [1:0]  mode_i;
    logic [15:0] data_i;
    logic        in_ready_o, out_valid_o, neg_o;
    logic [31:0] data_o;
`ifdef IMM_EXT_STATS_EN
    logic [15:0] stat_cnt_o;
    logic        in_ready3, out_valid3, neg3;
    logic [31:0] data3;
    logic [2:0]  stat3;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .mode_i(mode_i), .data_i(data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .data_o(data_o), .neg_o(neg_o)
`ifdef IMM_EXT_STATS_EN
        , .stat_cnt_o(stat_cnt_o)
`endif
    );

`ifdef IMM_EXT_STATS_EN
    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAT_W(3)) dut3 (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready3),
        .mode_i(mode_i), .data_i(data_i),
        .out_valid_o(out_valid3), .out_ready_i(out_ready_i),
        .data_o(data3), .neg_o(neg3), .stat_cnt_o(stat3)
    );
`endif

    // Reference: the block behaves as a 2-deep queue of extended values.
    logic [31:0] q[$];
    int          fire_cnt  = 0;
    bit          dat_known = 1'b1;

    function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] d);
        longint sv;
        longint r;
        sv = (d >= 16'h8000) ? longint'(d) - 65536 : longint'(d);
        case (m)
            2'd0:    r = sv;
            2'd1:    r = longint'(d);
            2'd2:    r = longint'(d) * 65536;
            default: r = sv * 4;
        endcase
        return r[31:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called #1 after a rising edge; drives one cycle, checks, advances the model at the edge.
    task automatic step(input logic r, input logic f, input logic v, input logic [1:0] m,
                        input logic [15:0] d, input logic ordy, output logic fired);
        logic in_f, out_f;
        rst_i = r; flush_i = f; in_valid_i = v; mode_i = m; data_i = d; out_ready_i = ordy;
        #1;
        chk("in_ready", in_ready_o, (q.size() < 2) && !r);
        chk("out_valid", out_valid_o, q.size() > 0);
        if (q.size() > 0) begin
            chk("data", data_o, q[0]);
            chk("neg", neg_o, q[0][31]);
        end else begin
            chk("neg_idle", neg_o, 1'b0);
            if (dat_known) chk("data_reset", data_o, 32'h0);
        end
`ifdef IMM_EXT_STATS_EN
        chk("stat16", stat_cnt_o, (fire_cnt > 65535) ? 65535 : fire_cnt);
        chk("stat3", stat3, (fire_cnt > 7) ? 7 : fire_cnt);
        chk("out_valid_w3", out_valid3, q.size() > 0);
`endif
        in_f  = v && (q.size() < 2) && !r;
        out_f = (q.size() > 0) && ordy;
        fired = in_f;
        @(posedge clk);
        if (r) begin
            q.delete();
            fire_cnt  = 0;
            dat_known = 1'b1;
        end else begin
            if (out_f) begin
                void'(q.pop_front());
                fire_cnt++;
            end
            if (f) q.delete();
            else if (in_f) begin
                q.push_back(ref_ext(m, d));
                dat_known = 1'b0;
            end
        end
        #1;
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tab[8];

    initial begin
        logic fd;
        int   sent;
        bit   saw_stall;

        tab[0] = '{2'd0, 16'h8001, 32'hFFFF8001};
        tab[1] = '{2'd1, 16'h8001, 32'h00008001};
        tab[2] = '{2'd2, 16'h8001, 32'h80010000};
        tab[3] = '{2'd3, 16'h8001, 32'hFFFE0004};
        tab[4] = '{2'd0, 16'h7FFF, 32'h00007FFF};
        tab[5] = '{2'd3, 16'h7FFF, 32'h0001FFFC};
        tab[6] = '{2'd2, 16'h7FFF, 32'h7FFF0000};
        tab[7] = '{2'd1, 16'hFFFF, 32'h0000FFFF};

        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; mode_i = 2'd0;
        data_i = 16'h0; out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, fd);

        // Back-to-back vectors with spec constants, one result per cycle.
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, tab[i].mode, tab[i].data, 1, fd);
            chk("tab_data", data_o, tab[i].exp);
            chk("tab_neg", neg_o, tab[i].exp[31]);
        end
        step(0, 0, 0, 0, 0, 1, fd);

        // Four inputs with the consumer stalled in cycles 2-4.
        sent = 0; saw_stall = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            step(0, 0, sent < 4, 2'(c), 16'h1230 + 16'(sent), !(c >= 2 && c <= 4), fd);
            if (fd) sent++;
            if (!in_ready_o) saw_stall = 1'b1;
        end
        chk("stall_sent", sent, 4);
        chk("stall_backpressure", saw_stall, 1'b1);

        // Flush with OR and SK full and a third input waiting.
        step(0, 0, 1, 0, 16'hA001, 0, fd);
        step(0, 0, 1, 1, 16'hA002, 0, fd);
        step(0, 1, 1, 2, 16'hA003, 0, fd);
        chk("flush_out_valid", out_valid_o, 1'b0);
        chk("flush_in_ready", in_ready_o, 1'b1);
        repeat (3) step(0, 0, 0, 0, 0, 1, fd);
        // Flush with an input firing into an empty SK: dropped too.
        step(0, 0, 1, 0, 16'hB001, 0, fd);
        step(0, 1, 1, 3, 16'hB002, 0, fd);
        chk("flush2_out_valid", out_valid_o, 1'b0);
        repeat (2) step(0, 0, 0, 0, 0, 1, fd);

        // Counter: a run of fires (saturates the 3-bit instance), then reset mid-stream.
        for (int i = 0; i < 12; i++) step(0, 0, 1, 2'(i), 16'(i * 7), 1, fd);
        step(0, 0, 1, 0, 16'hC001, 0, fd);
        step(1, 0, 1, 0, 16'hC002, 0, fd);
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_data", data_o, 32'h0);
        step(0, 0, 0, 0, 0, 1, fd);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) != 0, 2'($urandom), 16'($urandom),
                 $urandom_range(0, 2) != 0, fd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
